// File: rtl/esl_clk_check_pkg.sv
// Shared definitions for the clock-check block: result encoding, flag-generator
// FSM states and a common state-code type used when decoding FSMs from registers.
package esl_clk_check_pkg;

    localparam logic [1:0] RES_OK      = 2'b00;
    localparam logic [1:0] RES_SLOW    = 2'b01;
    localparam logic [1:0] RES_FAST    = 2'b10;
    localparam logic [1:0] RES_STOPPED = 2'b11;

    typedef enum logic [1:0] {
        MONITOR   = 2'd0,
        FAULTED   = 2'd1,
        INT_ERROR = 2'd2
    } flag_state_e;

    typedef logic [3:0] fsm_state_code_t;

    // Flag-generator states occupy the upper half of the shared code space.
    localparam fsm_state_code_t FLAG_CODE_BASE = 4'h8;

    function automatic fsm_state_code_t flag_state_code(input flag_state_e state);
        return FLAG_CODE_BASE | fsm_state_code_t'(state);
    endfunction

    function automatic logic [1:0] classify(input logic stopped,
                                            input logic below_lo,
                                            input logic above_hi);
        if (stopped)
            return RES_STOPPED;
        else if (below_lo)
            return RES_SLOW;
        else if (above_hi)
            return RES_FAST;
        else
            return RES_OK;
    endfunction

endpackage

// File: rtl/esl_clk_check_flag_gen.sv
// Classifies each end-of-window cut-clock count, filters transient failures and
// drives a sticky dual-rail clock-fault flag plus the latched internal-error flag.
module esl_clk_check_flag_gen
    import esl_clk_check_pkg::*;
#(
    parameter  int CNT_W      = 16,
    parameter  int FAIL_LIMIT = 3,
    localparam int FCW        = $clog2(FAIL_LIMIT + 1)
) (
    input  logic             ref_clk,
    input  logic             ref_rst_n,
    input  logic             en_flag_gen,
    input  logic             cut_clock_stopped,
    input  logic [CNT_W-1:0] cut_count,
    input  logic [CNT_W-1:0] thresh_lo,
    input  logic [CNT_W-1:0] thresh_hi,
    input  logic             clear_flags,
    output logic             check_done,
    output logic [1:0]       last_result,
    output logic [FCW-1:0]   fail_count,
    output logic             clk_fault,
    output logic             clk_fault_n,
    output logic [1:0]       fault_cause,
    output logic             flag_int_error
);

    localparam logic [FCW-1:0] LIMIT = FCW'(FAIL_LIMIT);

    flag_state_e    state_q;
    logic           check_done_q;
    logic [1:0]     last_result_q;
    logic [FCW-1:0] fail_count_q;
    logic           clk_fault_q;
    logic           clk_fault_n_q;
    logic [1:0]     fault_cause_q;
    logic           int_error_q;
    logic           en_prev_q;

    logic [1:0]     result_d;
    logic           clear_d;
    logic [FCW-1:0] fail_base_d;
    logic [FCW-1:0] fail_count_d;
    logic           fault_d;
    logic           int_error_d;

    // A clear in the same cycle as an evaluation takes effect first, so the
    // evaluation counts from zero and may re-fault from a freshly cleared state.
    always_comb begin
        result_d    = classify(cut_clock_stopped, cut_count < thresh_lo, cut_count > thresh_hi);
        clear_d     = clear_flags && (state_q != INT_ERROR);
        fail_base_d = clear_d ? '0 : fail_count_q;
        if (result_d == RES_OK)
            fail_count_d = '0;
        else if (result_d == RES_STOPPED || fail_base_d >= LIMIT)
            fail_count_d = LIMIT;
        else
            fail_count_d = fail_base_d + FCW'(1);
        fault_d     = (fail_count_d == LIMIT) && ((state_q == MONITOR) || clear_d);
        int_error_d = (en_flag_gen && (thresh_lo > thresh_hi))
                   || (en_flag_gen && en_prev_q)
                   || (clk_fault_q == clk_fault_n_q);
    end

    always_ff @(posedge ref_clk) begin
        if (!ref_rst_n) begin
            state_q       <= MONITOR;
            check_done_q  <= 1'b0;
            last_result_q <= RES_OK;
            fail_count_q  <= '0;
            clk_fault_q   <= 1'b0;
            clk_fault_n_q <= 1'b1;
            fault_cause_q <= RES_OK;
            int_error_q   <= 1'b0;
            en_prev_q     <= 1'b0;
        end else begin
            en_prev_q    <= en_flag_gen;
            check_done_q <= 1'b0;
            case (state_q)
                INT_ERROR: begin
                    clk_fault_q   <= 1'b1;
                    clk_fault_n_q <= 1'b0;
                    int_error_q   <= 1'b1;
                end
                default: begin
                    if (int_error_d) begin
                        state_q       <= INT_ERROR;
                        clk_fault_q   <= 1'b1;
                        clk_fault_n_q <= 1'b0;
                        int_error_q   <= 1'b1;
                    end else begin
                        if (clear_d) begin
                            state_q       <= MONITOR;
                            clk_fault_q   <= 1'b0;
                            clk_fault_n_q <= 1'b1;
                            fault_cause_q <= RES_OK;
                            fail_count_q  <= '0;
                        end
                        // Once faulted, the first cause is kept until software clears it.
                        if (en_flag_gen) begin
                            check_done_q  <= 1'b1;
                            last_result_q <= result_d;
                            fail_count_q  <= fail_count_d;
                            if (fault_d) begin
                                state_q       <= FAULTED;
                                clk_fault_q   <= 1'b1;
                                clk_fault_n_q <= 1'b0;
                                fault_cause_q <= result_d;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign check_done     = check_done_q;
    assign last_result    = last_result_q;
    assign fail_count     = fail_count_q;
    assign clk_fault      = clk_fault_q;
    assign clk_fault_n    = clk_fault_n_q;
    assign fault_cause    = fault_cause_q;
    assign flag_int_error = int_error_q;

endmodule

// File: tb/tb_esl_clk_check_flag_gen.sv
// Scoreboard bench for esl_clk_check_flag_gen: each enable pushes its expected
// result and a monitor pops and compares whenever check_done pulses.
module tb_esl_clk_check_flag_gen;

    logic        ref_clk = 1'b0;
    logic        ref_rst_n;
    logic        en_flag_gen;
    logic        cut_clock_stopped;
    logic [15:0] cut_count;
    logic [15:0] thresh_lo;
    logic [15:0] thresh_hi;
    logic        clear_flags;
    logic        check_done;
    logic [1:0]  last_result;
    logic [1:0]  fail_count;
    logic        clk_fault;
    logic        clk_fault_n;
    logic [1:0]  fault_cause;
    logic        flag_int_error;

    int checkCount = 0;
    int passCount  = 0;
    int cycleCount = 0;

    typedef struct {
        logic [1:0] result;
        logic [1:0] failCnt;
        logic       fault;
        logic [1:0] cause;
        int         cycle;
    } expect_t;

    expect_t expectQ[$];

    esl_clk_check_flag_gen dut (
        .ref_clk          (ref_clk),
        .ref_rst_n        (ref_rst_n),
        .en_flag_gen      (en_flag_gen),
        .cut_clock_stopped(cut_clock_stopped),
        .cut_count        (cut_count),
        .thresh_lo        (thresh_lo),
        .thresh_hi        (thresh_hi),
        .clear_flags      (clear_flags),
        .check_done       (check_done),
        .last_result      (last_result),
        .fail_count       (fail_count),
        .clk_fault        (clk_fault),
        .clk_fault_n      (clk_fault_n),
        .fault_cause      (fault_cause),
        .flag_int_error   (flag_int_error)
    );

    always #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) cycleCount <= cycleCount + 1;

    // Monitor: every check_done pulse must match the oldest outstanding expectation.
    always @(negedge ref_clk) begin
        expect_t e;
        if (check_done) begin
            checkCount++;
            if (expectQ.size() == 0) begin
                $display("[TB] FAIL unexpected_check_done: pulse at cycle %0d, required none", cycleCount);
            end else begin
                e = expectQ.pop_front();
                if (last_result === e.result && fail_count === e.failCnt && clk_fault === e.fault
                    && clk_fault_n === ~e.fault && fault_cause === e.cause && cycleCount == e.cycle)
                    passCount++;
                else
                    $display("[TB] FAIL result_cycle%0d: got res=%b cnt=%0d flt=%b fltn=%b cause=%b at cycle %0d, required res=%b cnt=%0d flt=%b fltn=%b cause=%b at cycle %0d",
                             e.cycle, last_result, fail_count, clk_fault, clk_fault_n, fault_cause, cycleCount,
                             e.result, e.failCnt, e.fault, ~e.fault, e.cause, e.cycle);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic [15:0] count, input logic stopped, input logic clr,
                                 input logic expectResult, input logic [1:0] eRes,
                                 input logic [1:0] eCnt, input logic eFlt, input logic [1:0] eCause);
        expect_t e;
        @(negedge ref_clk);
        en_flag_gen       = 1'b1;
        cut_count         = count;
        cut_clock_stopped = stopped;
        clear_flags       = clr;
        if (expectResult) begin
            e.result  = eRes;
            e.failCnt = eCnt;
            e.fault   = eFlt;
            e.cause   = eCause;
            e.cycle   = cycleCount + 1;
            expectQ.push_back(e);
        end
        @(negedge ref_clk);
        en_flag_gen       = 1'b0;
        cut_clock_stopped = 1'b0;
        clear_flags       = 1'b0;
        @(negedge ref_clk);
    endtask

    task automatic applyClear();
        @(negedge ref_clk);
        clear_flags = 1'b1;
        @(negedge ref_clk);
        clear_flags = 1'b0;
        @(negedge ref_clk);
    endtask

    task automatic applyReset();
        @(negedge ref_clk);
        ref_rst_n = 1'b0;
        @(negedge ref_clk);
        ref_rst_n = 1'b1;
    endtask

    // Expected vector order: check_done, last_result, fail_count, clk_fault, clk_fault_n, fault_cause, flag_int_error.
    task automatic checkOutput(input string name, input logic [9:0] required);
        logic [9:0] actual;
        actual = {check_done, last_result, fail_count, clk_fault, clk_fault_n, fault_cause, flag_int_error};
        checkCount++;
        if (actual === required)
            passCount++;
        else
            $display("[TB] FAIL %s: got done/res/cnt/flt/fltn/cause/err=%b, required %b", name, actual, required);
    endtask

    initial begin
        int waitCycles;
        ref_rst_n         = 1'b0;
        en_flag_gen       = 1'b0;
        cut_clock_stopped = 1'b0;
        cut_count         = 16'd0;
        thresh_lo         = 16'd1000;
        thresh_hi         = 16'd1100;
        clear_flags       = 1'b0;
        repeat (3) @(negedge ref_clk);
        checkOutput("reset_state", 10'b0_00_00_0_1_00_0);
        ref_rst_n = 1'b1;

        $display("[TB] in-range counts including both thresholds");
        applyStimulus(16'd1000, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 2'b00);
        applyStimulus(16'd1100, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 2'b00);
        applyStimulus(16'd1050, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 2'b00);

        $display("[TB] three consecutive failures raise the fault");
        applyStimulus(16'd999,  1'b0, 1'b0, 1'b1, 2'b01, 2'd1, 1'b0, 2'b00);
        applyStimulus(16'd1101, 1'b0, 1'b0, 1'b1, 2'b10, 2'd2, 1'b0, 2'b00);
        applyStimulus(16'd999,  1'b0, 1'b0, 1'b1, 2'b01, 2'd3, 1'b1, 2'b01);
        applyStimulus(16'd1050, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0, 1'b1, 2'b01);
        checkOutput("fault_sticky", 10'b0_00_00_1_0_01_0);
        applyClear();
        checkOutput("clear_after_fault", 10'b0_00_00_0_1_00_0);

        $display("[TB] an OK result resets the filter");
        applyStimulus(16'd999,  1'b0, 1'b0, 1'b1, 2'b01, 2'd1, 1'b0, 2'b00);
        applyStimulus(16'd1050, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 2'b00);
        applyStimulus(16'd999,  1'b0, 1'b0, 1'b1, 2'b01, 2'd1, 1'b0, 2'b00);
        applyStimulus(16'd999,  1'b0, 1'b0, 1'b1, 2'b01, 2'd2, 1'b0, 2'b00);

        $display("[TB] stopped clock faults immediately");
        applyStimulus(16'd1050, 1'b1, 1'b0, 1'b1, 2'b11, 2'd3, 1'b1, 2'b11);
        applyClear();
        checkOutput("clear_after_stop", 10'b0_11_00_0_1_00_0);

        $display("[TB] clear with enable, saturation and first cause");
        applyStimulus(16'd1050, 1'b1, 1'b0, 1'b1, 2'b11, 2'd3, 1'b1, 2'b11);
        applyStimulus(16'd2000, 1'b0, 1'b1, 1'b1, 2'b10, 2'd1, 1'b0, 2'b00);
        applyStimulus(16'd999,  1'b0, 1'b0, 1'b1, 2'b01, 2'd2, 1'b0, 2'b00);
        applyStimulus(16'd999,  1'b0, 1'b0, 1'b1, 2'b01, 2'd3, 1'b1, 2'b01);
        applyStimulus(16'd1101, 1'b0, 1'b0, 1'b1, 2'b10, 2'd3, 1'b1, 2'b01);
        applyClear();
        checkOutput("clear_after_saturate", 10'b0_10_00_0_1_00_0);

        $display("[TB] full-range unsigned extremes");
        applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b1, 2'b10, 2'd1, 1'b0, 2'b00);
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1, 2'b01, 2'd2, 1'b0, 2'b00);
        applyStimulus(16'd1050, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 2'b00);

        $display("[TB] inverted thresholds latch the internal error");
        thresh_lo = 16'd1200;
        applyStimulus(16'd1050, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0, 2'b00);
        checkOutput("int_error_thresh", 10'b0_00_00_1_0_00_1);
        thresh_lo = 16'd1000;
        applyClear();
        checkOutput("int_error_ignores_clear", 10'b0_00_00_1_0_00_1);
        applyStimulus(16'd999, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0, 2'b00);
        checkOutput("int_error_frozen", 10'b0_00_00_1_0_00_1);
        applyReset();
        @(negedge ref_clk);
        checkOutput("reset_from_int_error", 10'b0_00_00_0_1_00_0);

        $display("[TB] back-to-back enables latch the internal error");
        @(negedge ref_clk);
        en_flag_gen = 1'b1;
        cut_count   = 16'd999;
        expectQ.push_back('{result: 2'b01, failCnt: 2'd1, fault: 1'b0, cause: 2'b00, cycle: cycleCount + 1});
        @(negedge ref_clk);
        @(negedge ref_clk);
        en_flag_gen = 1'b0;
        @(negedge ref_clk);
        checkOutput("int_error_double_enable", 10'b0_01_01_1_0_00_1);
        applyReset();
        @(negedge ref_clk);
        checkOutput("final_reset", 10'b0_00_00_0_1_00_0);

        waitCycles = 0;
        while (expectQ.size() != 0 && waitCycles < 20) begin
            @(negedge ref_clk);
            waitCycles++;
        end
        if (expectQ.size() != 0) begin
            checkCount += expectQ.size();
            $display("[TB] FAIL missing_check_done: %0d results outstanding, required 0", expectQ.size());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
